// File: rtl/led_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with frame-synchronous (tear-free) data update.
// Optional build macro LED_LZ_BLANK_EN enables leading-zero blanking.
module led_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 16
) (
   input  logic                  Clk_O,
   input  logic                  Reset,
   input  logic [4*DIGITS-1:0]   Data_In,
   input  logic                  Load,
   output logic [6:0]            SEG,
   output logic [DIGITS-1:0]     AN,
   output logic                  Frame_Start,
   output logic                  Pending
);

   localparam int DIVW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int DIGW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
   localparam logic [DIGW-1:0] DIG_LAST = DIGW'(DIGITS - 1);

   logic [DIVW-1:0]     div_q, div_d;
   logic [DIGW-1:0]     dig_q, dig_d;
   logic [4*DIGITS-1:0] shown_q, shown_d;
   logic [4*DIGITS-1:0] pval_q, pval_d;
   logic                pend_q, pend_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                fs_q, fs_d;
   logic                wrap;
   logic [3:0]          nib;
   logic                blank;
`ifdef LED_LZ_BLANK_EN
   logic [DIGITS:0]     zero_above;
`endif

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      div_d   = div_q;
      dig_d   = dig_q;
      shown_d = shown_q;
      pval_d  = pval_q;
      pend_d  = pend_q;
      wrap    = 1'b0;
      nib     = 4'h0;
      blank   = 1'b0;
      an_d    = '1;

      if (div_q == DIV_LAST) begin
         div_d = '0;
         if (dig_q == DIG_LAST) begin
            dig_d = '0;
            wrap  = 1'b1;
         end else begin
            dig_d = dig_q + 1'b1;
         end
      end else begin
         div_d = div_q + 1'b1;
      end

      // shown only ever changes on the wrap edge; a Load landing there bypasses pval
      if (wrap) begin
         if (Load) begin
            shown_d = Data_In;
            pend_d  = 1'b0;
         end else if (pend_q) begin
            shown_d = pval_q;
            pend_d  = 1'b0;
         end
      end else if (Load) begin
         pval_d = Data_In;
         pend_d = 1'b1;
      end

`ifdef LED_LZ_BLANK_EN
      zero_above         = '0;
      zero_above[DIGITS] = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         zero_above[DIGITS-1-i] = zero_above[DIGITS-i] && (shown_d[4*(DIGITS-1-i) +: 4] == 4'h0);
      end
`endif

      // outputs are computed from post-edge state so they line up with it
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (dig_d == DIGW'(i)) begin
            nib = shown_d[4*i +: 4];
`ifdef LED_LZ_BLANK_EN
            blank = (i != 0) && zero_above[i];
`endif
            if (div_d != '0) an_d[i] = 1'b0;
         end
      end

      seg_d = blank ? 7'h7F : hex7(nib);
      fs_d  = wrap;
   end

   always_ff @(posedge Clk_O) begin
      if (Reset) begin
         div_q   <= '0;
         dig_q   <= '0;
         shown_q <= '0;
         pval_q  <= '0;
         pend_q  <= 1'b0;
         seg_q   <= 7'h7F;
         an_q    <= '1;
         fs_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         dig_q   <= dig_d;
         shown_q <= shown_d;
         pval_q  <= pval_d;
         pend_q  <= pend_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         fs_q    <= fs_d;
      end
   end

   assign SEG         = seg_q;
   assign AN          = an_q;
   assign Frame_Start = fs_q;
   assign Pending     = pend_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with DIGITS=4, SCAN_DIV=4 (16-cycle frame).
// Expectations follow LED_LZ_BLANK_EN when it is defined for the build.
module tb_led_scan_driver;

   logic        clk = 1'b0;
   logic        Reset;
   logic [15:0] Data_In;
   logic        Load;
   logic [6:0]  SEG;
   logic [3:0]  AN;
   logic        Frame_Start;
   logic        Pending;

   int total = 0;
   int bad   = 0;
   int c     = 0;

   led_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
      .Clk_O(clk), .Reset(Reset), .Data_In(Data_In), .Load(Load),
      .SEG(SEG), .AN(AN), .Frame_Start(Frame_Start), .Pending(Pending)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hexseg(input logic [3:0] n);
      logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[n];
   endfunction

   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
      logic [15:0] s;
      s = v >> (4*d);
`ifdef LED_LZ_BLANK_EN
      if (d > 0 && s == 16'h0) return 7'h7F;
`endif
      return hexseg(s[3:0]);
   endfunction

   function automatic logic [3:0] exp_an(input int cc);
      logic [3:0] one;
      one = 4'b0001;
      if (cc % 4 == 0) return 4'hF;
      return ~(one << ((cc / 4) % 4));
   endfunction

   // c = number of edges since reset release; outputs observed reflect state c
   task automatic step();
      @(posedge clk);
      #1;
      c++;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Load = 1'b1; Data_In = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (SEG !== 7'h7F) begin bad++; $display("FAIL reset_seg c=%0d got=%h exp=7f", i, SEG); end
         total++; if (AN !== 4'hF) begin bad++; $display("FAIL reset_an c=%0d got=%h exp=f", i, AN); end
         total++; if (Frame_Start !== 1'b0) begin bad++; $display("FAIL reset_fs c=%0d got=%b exp=0", i, Frame_Start); end
         total++; if (Pending !== 1'b0) begin bad++; $display("FAIL reset_pend c=%0d got=%b exp=0", i, Pending); end
      end
      Load = 1'b0; Data_In = 16'h0; Reset = 1'b0; c = 0;
   endtask

   task automatic test_load_frame();
      while (c < 3) begin
         step();
         total++; if (Pending !== 1'b0) begin bad++; $display("FAIL pre_load_pend c=%0d got=%b exp=0", c, Pending); end
         total++; if (SEG !== 7'h40) begin bad++; $display("FAIL pre_load_seg c=%0d got=%h exp=40", c, SEG); end
      end
      Load = 1'b1; Data_In = 16'h12AF;
      step();
      Load = 1'b0; Data_In = 16'h0;
      while (c < 16) begin
         total++; if (Pending !== 1'b1) begin bad++; $display("FAIL load_pend c=%0d got=%b exp=1", c, Pending); end
         total++; if (Frame_Start !== 1'b0) begin bad++; $display("FAIL load_fs c=%0d got=%b exp=0", c, Frame_Start); end
         step();
      end
      while (c < 32) begin
         total++; if (SEG !== exp_seg(16'h12AF, (c/4)%4)) begin bad++; $display("FAIL frame_seg c=%0d got=%h exp=%h", c, SEG, exp_seg(16'h12AF, (c/4)%4)); end
         total++; if (AN !== exp_an(c)) begin bad++; $display("FAIL frame_an c=%0d got=%h exp=%h", c, AN, exp_an(c)); end
         total++; if (Frame_Start !== (c == 16)) begin bad++; $display("FAIL frame_fs c=%0d got=%b exp=%b", c, Frame_Start, c == 16); end
         total++; if (Pending !== 1'b0) begin bad++; $display("FAIL frame_pend c=%0d got=%b exp=0", c, Pending); end
         step();
      end
   endtask

   task automatic test_last_wins();
      while (c < 64) begin
         logic [15:0] v;
         v = (c < 48) ? 16'h12AF : 16'h0002;
         total++; if (SEG !== exp_seg(v, (c/4)%4)) begin bad++; $display("FAIL lastwins_seg c=%0d got=%h exp=%h", c, SEG, exp_seg(v, (c/4)%4)); end
         total++; if (AN !== exp_an(c)) begin bad++; $display("FAIL lastwins_an c=%0d got=%h exp=%h", c, AN, exp_an(c)); end
         if (c == 33) begin Load = 1'b1; Data_In = 16'h0001; end
         if (c == 37) begin Load = 1'b1; Data_In = 16'h0002; end
         if (c == 63) begin
            total++; if (Pending !== 1'b0) begin bad++; $display("FAIL wrap_pre_pend c=%0d got=%b exp=0", c, Pending); end
            Load = 1'b1; Data_In = 16'h5555;
         end
         step();
         Load = 1'b0; Data_In = 16'h0;
      end
   endtask

   task automatic test_wrap_bypass();
      total++; if (Frame_Start !== 1'b1) begin bad++; $display("FAIL bypass_fs c=%0d got=%b exp=1", c, Frame_Start); end
      total++; if (Pending !== 1'b0) begin bad++; $display("FAIL bypass_pend c=%0d got=%b exp=0", c, Pending); end
      total++; if (SEG !== 7'h12) begin bad++; $display("FAIL bypass_seg c=%0d got=%h exp=12", c, SEG); end
      total++; if (AN !== 4'hF) begin bad++; $display("FAIL bypass_an c=%0d got=%h exp=f", c, AN); end
      step();
      total++; if (Frame_Start !== 1'b0) begin bad++; $display("FAIL bypass_fs2 c=%0d got=%b exp=0", c, Frame_Start); end
      total++; if (SEG !== 7'h12) begin bad++; $display("FAIL bypass_seg2 c=%0d got=%h exp=12", c, SEG); end
      total++; if (AN !== 4'hE) begin bad++; $display("FAIL bypass_an2 c=%0d got=%h exp=e", c, AN); end
   endtask

   task automatic test_reset_mid();
      while (c < 70) step();
      Load = 1'b1; Data_In = 16'h1234;
      step();
      Load = 1'b0; Data_In = 16'h0;
      while (c < 73) step();
      total++; if (Pending !== 1'b1) begin bad++; $display("FAIL mid_pend c=%0d got=%b exp=1", c, Pending); end
      total++; if (AN !== 4'hB) begin bad++; $display("FAIL mid_an c=%0d got=%h exp=b", c, AN); end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      total++; if (SEG !== 7'h7F) begin bad++; $display("FAIL mid_rst_seg got=%h exp=7f", SEG); end
      total++; if (AN !== 4'hF) begin bad++; $display("FAIL mid_rst_an got=%h exp=f", AN); end
      total++; if (Frame_Start !== 1'b0) begin bad++; $display("FAIL mid_rst_fs got=%b exp=0", Frame_Start); end
      total++; if (Pending !== 1'b0) begin bad++; $display("FAIL mid_rst_pend got=%b exp=0", Pending); end
      c = 0;
      while (c < 16) begin
         step();
         total++; if (SEG !== exp_seg(16'h0, (c/4)%4)) begin bad++; $display("FAIL post_rst_seg c=%0d got=%h exp=%h", c, SEG, exp_seg(16'h0, (c/4)%4)); end
         total++; if (AN !== exp_an(c)) begin bad++; $display("FAIL post_rst_an c=%0d got=%h exp=%h", c, AN, exp_an(c)); end
         total++; if (Pending !== 1'b0) begin bad++; $display("FAIL post_rst_pend c=%0d got=%b exp=0", c, Pending); end
         total++; if (Frame_Start !== (c == 16)) begin bad++; $display("FAIL post_rst_fs c=%0d got=%b exp=%b", c, Frame_Start, c == 16); end
      end
   endtask

   task automatic test_leading_zero();
      while (c < 64) begin
         if (c >= 32) begin
            logic [15:0] v;
            v = (c < 48) ? 16'h0030 : 16'h0000;
            total++; if (SEG !== exp_seg(v, (c/4)%4)) begin bad++; $display("FAIL lz_seg c=%0d got=%h exp=%h", c, SEG, exp_seg(v, (c/4)%4)); end
            total++; if (AN !== exp_an(c)) begin bad++; $display("FAIL lz_an c=%0d got=%h exp=%h", c, AN, exp_an(c)); end
         end
         if (c == 20) begin Load = 1'b1; Data_In = 16'h0030; end
         if (c == 36) begin Load = 1'b1; Data_In = 16'h0000; end
         step();
         Load = 1'b0; Data_In = 16'h0;
      end
   endtask

   initial begin
      Reset = 1'b1; Load = 1'b0; Data_In = 16'h0;
      #2;
      test_reset();
      test_load_frame();
      test_last_wins();
      test_wrap_bypass();
      test_reset_mid();
      test_leading_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
